// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port core memory between the instruction-fetch
// port and the load/store data port.
//
// Each accepted request takes one of two paths:
//   IDLE -> ACCESS -> IDLE           for a store
//   IDLE -> ACCESS -> RESP -> IDLE   for a load or a fetch
//
// Handshake on both ports (req/gnt/rvalid):
//   - The requester holds req, addr and data stable until it sees gnt high.
//   - gnt is combinational and can only assert in IDLE. It is the one-cycle
//     acceptance strobe.
//   - rvalid pulses once, two cycles after gnt, and only for reads.
//   - rdata follows the memory during the rvalid cycle. After that it holds the
//     last read word for that port until its next rvalid.
//
// Build option MEM_ARB_ROUND_ROBIN_EN:
//   - Defined: on contention the port that did not win last time is granted.
//   - Undefined: the data port always wins contention.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_write_enable,
   output logic              mem_read_enable,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_input_data,
   input  logic [DATA_W-1:0] mem_output_data,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Owner encoding, shared by owner_q and last_winner_q.
   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              grant_if, grant_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic              last_winner_q, last_winner_d;
`endif

   // Arbitration: grants only in IDLE and never while reset is asserted.
   // A lone requester always wins; contention is resolved by the build option.
   always_comb begin
      grant_if = 1'b0;
      grant_d  = 1'b0;
      if (state_q == IDLE && !reset) begin
         if (if_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (last_winner_q == OWN_D) begin
               grant_if = 1'b1;
            end else begin
               grant_d = 1'b1;
            end
`else
            grant_d = 1'b1;
`endif
         end else begin
            grant_if = if_req;
            grant_d  = d_req;
         end
      end
   end

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Remember which port took the last grant, so the other port wins the next tie.
   always_comb begin
      last_winner_d = last_winner_q;
      if (grant_d) begin
         last_winner_d = OWN_D;
      end else if (grant_if) begin
         last_winner_d = OWN_IF;
      end
   end
`endif

   // Next-state, command capture and port outputs of the access FSM.
   always_comb begin
      state_d          = state_q;
      owner_d          = owner_q;
      we_d             = we_q;
      addr_d           = addr_q;
      wdata_d          = wdata_q;
      if_rdata_d       = if_rdata_q;
      d_rdata_d        = d_rdata_q;
      if_gnt           = grant_if;
      d_gnt            = grant_d;
      if_rvalid        = 1'b0;
      d_rvalid         = 1'b0;
      mem_write_enable = 1'b0;
      mem_read_enable  = 1'b0;
      mem_address      = '0;
      mem_input_data   = '0;

      case (state_q)
         IDLE: begin
            if (grant_d) begin
               owner_d = OWN_D;
               we_d    = d_we;
               addr_d  = d_addr;
               wdata_d = d_wdata;
               state_d = ACCESS;
            end else if (grant_if) begin
               // The fetch port only ever reads.
               owner_d = OWN_IF;
               we_d    = 1'b0;
               addr_d  = if_addr;
               wdata_d = '0;
               state_d = ACCESS;
            end
         end

         ACCESS: begin
            // Drive the registered command for exactly one cycle.
            mem_address      = addr_q;
            mem_input_data   = wdata_q;
            mem_write_enable = we_q;
            mem_read_enable  = !we_q;
            state_d          = we_q ? IDLE : RESP;
         end

         RESP: begin
            // Memory data is valid this cycle. Pass it through and keep a copy.
            // A reset in this cycle drops the response.
            if (!reset) begin
               if (owner_q == OWN_D) begin
                  d_rvalid  = 1'b1;
                  d_rdata_d = mem_output_data;
               end else begin
                  if_rvalid  = 1'b1;
                  if_rdata_d = mem_output_data;
               end
            end
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if_rdata = if_rvalid ? mem_output_data : if_rdata_q;
      d_rdata  = d_rvalid  ? mem_output_data : d_rdata_q;
      busy     = (state_q != IDLE);
   end

   // State and capture registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         owner_q    <= OWN_D;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Round-robin history register; reset to DATA so the fetch port wins the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_winner_q <= OWN_D;
      end else begin
         last_winner_q <= last_winner_d;
      end
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. It includes a small single-port memory with one-cycle
// read latency. Directed stimulus pushes expected grants, writes and read data
// into queues, and a negedge monitor pops and compares them.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_gnt;
   logic          d_rvalid;
   logic [DW-1:0] d_rdata;
   logic          mem_write_enable;
   logic          mem_read_enable;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_input_data;
   logic [DW-1:0] mem_output_data;
   logic          busy;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk              (clk),
      .reset            (reset),
      .if_req           (if_req),
      .if_addr          (if_addr),
      .if_gnt           (if_gnt),
      .if_rvalid        (if_rvalid),
      .if_rdata         (if_rdata),
      .d_req            (d_req),
      .d_we             (d_we),
      .d_addr           (d_addr),
      .d_wdata          (d_wdata),
      .d_gnt            (d_gnt),
      .d_rvalid         (d_rvalid),
      .d_rdata          (d_rdata),
      .mem_write_enable (mem_write_enable),
      .mem_read_enable  (mem_read_enable),
      .mem_address      (mem_address),
      .mem_input_data   (mem_input_data),
      .mem_output_data  (mem_output_data),
      .busy             (busy)
   );

   // Clock and global time limit.
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Core memory model: one-cycle registered read, write on the rising edge.
   logic [DW-1:0] mem_arr [0:255] = '{4: 32'h00500093, default: 32'h0};
   logic [DW-1:0] mem_out_r = '0;

   always @(posedge clk) begin
      if (mem_write_enable) mem_arr[mem_address[7:0]] <= mem_input_data;
      if (mem_read_enable)  mem_out_r <= mem_arr[mem_address[7:0]];
   end
   assign mem_output_data = mem_out_r;

   // Scoreboard state.
   logic [DW-1:0]    exp_if_q[$];
   logic [DW-1:0]    exp_d_q[$];
   logic             exp_gnt_q[$];   // 1 = data port, 0 = fetch port
   logic [AW+DW-1:0] exp_wr_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pop and compare whenever the DUT presents a grant, response or write.
   always @(negedge clk) begin
      if (if_gnt || d_gnt) begin
         check("one_gnt", 64'(if_gnt & d_gnt), 64'd0);
         if (exp_gnt_q.size() == 0) check("gnt_unexpected", 64'd1, 64'd0);
         else check("gnt_order", 64'(d_gnt), 64'(exp_gnt_q.pop_front()));
      end
      if (if_rvalid) begin
         check("if_gnt_with_rvalid", 64'(if_gnt), 64'd0);
         if (exp_if_q.size() == 0) check("if_rvalid_unexpected", 64'd1, 64'd0);
         else check("if_rdata", 64'(if_rdata), 64'(exp_if_q.pop_front()));
      end
      if (d_rvalid) begin
         check("d_gnt_with_rvalid", 64'(d_gnt), 64'd0);
         if (exp_d_q.size() == 0) check("d_rvalid_unexpected", 64'd1, 64'd0);
         else check("d_rdata", 64'(d_rdata), 64'(exp_d_q.pop_front()));
      end
      if (mem_write_enable) begin
         if (exp_wr_q.size() == 0) check("write_unexpected", 64'd1, 64'd0);
         else check("mem_write_cmd", {mem_address, mem_input_data}, exp_wr_q.pop_front());
      end
   end

   // Wait (bounded) for a grant: which = 0 fetch, 1 data, 2 either.
   task automatic wait_gnt(input int which);
      int  n    = 0;
      bit  seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         case (which)
            0:       seen = if_gnt;
            1:       seen = d_gnt;
            default: seen = if_gnt | d_gnt;
         endcase
      end
      if (!seen) check("gnt_timeout", 64'd0, 64'd1);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   logic exp_order [4];

   initial begin
      reset   = 1'b1;
      if_req  = 1'b1;
      d_req   = 1'b1;
      d_we    = 1'b0;
      if_addr = '0;
      d_addr  = '0;
      d_wdata = '0;

      // Reset held two cycles with both requests high.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_if_gnt",    64'(if_gnt), 64'd0);
      check("rst_d_gnt",     64'(d_gnt), 64'd0);
      check("rst_if_rvalid", 64'(if_rvalid), 64'd0);
      check("rst_d_rvalid",  64'(d_rvalid), 64'd0);
      check("rst_if_rdata",  64'(if_rdata), 64'd0);
      check("rst_d_rdata",   64'(d_rdata), 64'd0);
      check("rst_mem_we",    64'(mem_write_enable), 64'd0);
      check("rst_mem_re",    64'(mem_read_enable), 64'd0);
      check("rst_mem_addr",  64'(mem_address), 64'd0);
      check("rst_mem_in",    64'(mem_input_data), 64'd0);
      check("rst_busy",      64'(busy), 64'd0);
      if_req = 1'b0;
      d_req  = 1'b0;
      next_cycle();
      reset = 1'b0;

      // Data store to address 2 with value 8.
      next_cycle();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'd2; d_wdata = 32'd8;
      exp_gnt_q.push_back(1'b1);
      exp_wr_q.push_back({32'd2, 32'd8});
      wait_gnt(1);
      next_cycle();
      d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      check("st_wr_en",  64'(mem_write_enable), 64'd1);
      check("st_rd_en",  64'(mem_read_enable), 64'd0);
      check("st_addr",   64'(mem_address), 64'd2);
      check("st_wdata",  64'(mem_input_data), 64'd8);
      @(negedge clk);
      check("st_busy_done", 64'(busy), 64'd0);

      // Data load from address 2, which should return 8.
      next_cycle();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'd2;
      exp_gnt_q.push_back(1'b1);
      exp_d_q.push_back(32'd8);
      wait_gnt(1);
      next_cycle();
      d_req = 1'b0;
      @(negedge clk);
      check("ld_rd_en", 64'(mem_read_enable), 64'd1);
      check("ld_wr_en", 64'(mem_write_enable), 64'd0);
      check("ld_addr",  64'(mem_address), 64'd2);
      @(negedge clk);
      check("ld_rvalid_n2",    64'(d_rvalid), 64'd1);
      check("ld_rdata_n2",     64'(d_rdata), 64'd8);
      check("ld_if_rvalid_n2", 64'(if_rvalid), 64'd0);
      @(negedge clk);
      check("ld_rvalid_pulse", 64'(d_rvalid), 64'd0);
      check("ld_rdata_held",   64'(d_rdata), 64'd8);
      check("ld_busy_done",    64'(busy), 64'd0);

      // Instruction fetch from preloaded address 4.
      next_cycle();
      if_req = 1'b1; if_addr = 32'd4;
      exp_gnt_q.push_back(1'b0);
      exp_if_q.push_back(32'h00500093);
      wait_gnt(0);
      next_cycle();
      if_req = 1'b0;
      @(negedge clk);
      check("if_rd_en", 64'(mem_read_enable), 64'd1);
      check("if_addr",  64'(mem_address), 64'd4);
      @(negedge clk);
      check("if_rvalid_n2", 64'(if_rvalid), 64'd1);
      check("if_rdata_n2",  64'(if_rdata), 64'h00500093);
      check("if_d_rvalid",  64'(d_rvalid), 64'd0);
      @(negedge clk);
      check("if_busy_n3", 64'(busy), 64'd0);

      // Contention: both ports issue loads continuously for four operations.
      apply_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      for (int i = 0; i < 4; i++) begin
         exp_gnt_q.push_back(exp_order[i]);
         if (exp_order[i]) exp_d_q.push_back(32'd8);
         else exp_if_q.push_back(32'h00500093);
      end
      if_req = 1'b1; if_addr = 32'd4;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'd2;
      for (int i = 0; i < 4; i++) wait_gnt(2);
      next_cycle();
      if_req = 1'b0;
      d_req  = 1'b0;
      repeat (4) @(negedge clk);

      // Reset during the ACCESS cycle of a load: the response must be dropped.
      next_cycle();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'd2;
      exp_gnt_q.push_back(1'b1);
      wait_gnt(1);
      next_cycle();
      d_req = 1'b0;
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      check("rst_mid_busy",   64'(busy), 64'd0);
      check("rst_mid_rd_en",  64'(mem_read_enable), 64'd0);
      check("rst_mid_wr_en",  64'(mem_write_enable), 64'd0);
      check("rst_mid_rvalid", 64'(d_rvalid), 64'd0);
      repeat (3) @(negedge clk);

      // Fetch request raised during the RESP cycle of a data load.
      next_cycle();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'd2;
      exp_gnt_q.push_back(1'b1);
      exp_gnt_q.push_back(1'b0);
      exp_d_q.push_back(32'd8);
      exp_if_q.push_back(32'h00500093);
      wait_gnt(1);
      next_cycle();
      d_req = 1'b0;
      next_cycle();
      if_req = 1'b1; if_addr = 32'd4;
      @(negedge clk);
      check("resp_no_if_gnt", 64'(if_gnt), 64'd0);
      check("resp_d_rvalid",  64'(d_rvalid), 64'd1);
      @(negedge clk);
      check("idle_if_gnt", 64'(if_gnt), 64'd1);
      next_cycle();
      if_req = 1'b0;
      repeat (4) @(negedge clk);

      check("exp_gnt_q_empty", 64'(exp_gnt_q.size()), 64'd0);
      check("exp_if_q_empty",  64'(exp_if_q.size()), 64'd0);
      check("exp_d_q_empty",   64'(exp_d_q.size()), 64'd0);
      check("exp_wr_q_empty",  64'(exp_wr_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
